vga_sprite_motion_ctrl: RTL

Frame-synchronous position controller for the movable overlay box in the VGA pixel path. Takes the four active-low push buttons and the sync generator's vertical sync, then synchronises and debounces the buttons. Updates the box position once per frame, with edge clamping and hold-to-accelerate. Outputs X/Y plus the linear top-left pixel address consumed by the pixel compositor.

---
 rtl/vga_sprite_motion_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sprite_motion_ctrl.sv
// vga_sprite_motion_ctrl
// Frame-synchronous position controller for the movable overlay box.
// Buttons are synchronised and debounced, the box moves once per frame on
// the falling edge of vertical sync, with edge clamping and hold-to-accelerate.
// Optional build macro: SPRITE_WRAP_EN -- positions wrap around each axis
// (torus) instead of clamping at the screen edges.
module vga_sprite_motion_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int OBJ_W       = 50,
    parameter int OBJ_H       = 50,
    parameter int X_INIT      = 40,
    parameter int Y_INIT      = 1,
    parameter int DEB_CYCLES  = 250000,
    parameter int STEP_SLOW   = 1,
    parameter int STEP_FAST   = 4,
    parameter int RAMP_FRAMES = 30
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iVS,
    input  logic        mLeft,
    input  logic        mRight,
    input  logic        mUp,
    input  logic        mDown,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic [18:0] oTopLeft,
    output logic        oFrameTick,
    output logic        oFast
);

    localparam logic signed [10:0] MAX_X_S     = 11'(SCREEN_W - OBJ_W);
    localparam logic signed [10:0] MAX_Y_S     = 11'(SCREEN_H - OBJ_H);
    localparam logic signed [10:0] STEP_SLOW_S = 11'(STEP_SLOW);
    localparam logic signed [10:0] STEP_FAST_S = 11'(STEP_FAST);
    localparam logic [17:0]        DEB_LAST    = 18'(DEB_CYCLES - 1);
    localparam logic [4:0]         RAMP_CNT    = 5'(RAMP_FRAMES);
    localparam logic [9:0]         X_RST       = 10'(X_INIT);
    localparam logic [9:0]         Y_RST       = 10'(Y_INIT);
    localparam logic [18:0]        TL_RST      = 19'(Y_INIT * SCREEN_W + X_INIT);
    localparam logic [18:0]        STRIDE      = 19'(SCREEN_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } state_e;

    // Button vector order: [0]=left, [1]=right, [2]=up, [3]=down (active-low)
    logic [3:0]       raw_btn;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0][17:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       pressed;

    logic             vs_d_q;
    logic             tick;
    logic             frame_tick_q;

    logic signed [10:0] dx, dy;
    logic               any_move;
    logic signed [10:0] step;

    state_e           state_q, state_d;
    logic [4:0]       hold_q, hold_d;
    logic [4:0]       hold_inc;

    logic [9:0]       x_q, y_q;
    logic [9:0]       x_d, y_d;
    logic [18:0]      tl_q, tl_d;

    assign raw_btn = {mDown, mUp, mRight, mLeft};

    // Moves one axis by delta, then clamps (or wraps) into 0..lim.
    function automatic logic [9:0] move_axis(input logic [9:0]         cur,
                                             input logic signed [10:0] delta,
                                             input logic signed [10:0] lim);
        logic signed [10:0] sum;
        logic signed [10:0] res;
        sum = $signed({1'b0, cur}) + delta;
`ifdef SPRITE_WRAP_EN
        if (sum < 11'sd0)
            res = lim + 11'sd1 + sum;
        else if (sum > lim)
            res = sum - lim - 11'sd1;
        else
            res = sum;
`else
        if (sum < 11'sd0)
            res = 11'sd0;
        else if (sum > lim)
            res = lim;
        else
            res = sum;
`endif
        return 10'(res);
    endfunction

    // Two-flop synchroniser for the asynchronous buttons; released level on reset.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value; blocking here would collapse
            // the two synchroniser stages into one.
            sync1_q <= raw_btn;
            sync2_q <= sync1_q;
        end
    end

    // Per-button debounce: accept a new level after DEB_CYCLES stable cycles.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // branch would otherwise infer a latch.
        deb_cnt_d = deb_cnt_q;
        stable_d  = stable_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_cnt_d[i] = '0;
                stable_d[i]  = sync2_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 18'd1;
            end
        end
    end

    // Debounce counters and accepted levels.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            deb_cnt_q <= '0;
            stable_q  <= '1;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            stable_q  <= stable_d;
        end
    end

    assign pressed = ~stable_q;
    assign tick    = vs_d_q & ~iVS;

    // Vsync edge detector and registered frame tick.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_d_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            vs_d_q       <= iVS;
            frame_tick_q <= tick;
        end
    end

    // Axis directions; opposing buttons cancel on their axis.
    always_comb begin
        dx = 11'sd0;
        dy = 11'sd0;
        if (pressed[1] && !pressed[0])
            dx = 11'sd1;
        else if (pressed[0] && !pressed[1])
            dx = -11'sd1;
        if (pressed[3] && !pressed[2])
            dy = 11'sd1;
        else if (pressed[2] && !pressed[3])
            dy = -11'sd1;
        any_move = (dx != 11'sd0) || (dy != 11'sd0);
    end

    // Speed FSM next state; hold_cnt saturates at RAMP_FRAMES.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        hold_inc = (hold_q < RAMP_CNT) ? hold_q + 5'd1 : hold_q;
        case (state_q)
            ST_IDLE: begin
                if (any_move) begin
                    state_d = ST_SLOW;
                    hold_d  = 5'd1;
                end
            end
            ST_SLOW: begin
                if (!any_move) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_inc;
                    if (hold_inc == RAMP_CNT)
                        state_d = ST_FAST;
                end
            end
            ST_FAST: begin
                if (!any_move) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Step size follows the state being left; next position and address.
    always_comb begin
        step = (state_q == ST_FAST) ? STEP_FAST_S : STEP_SLOW_S;
        x_d  = move_axis(x_q, dx * step, MAX_X_S);
        y_d  = move_axis(y_q, dy * step, MAX_Y_S);
        tl_d = {9'd0, y_d} * STRIDE + {9'd0, x_d};
    end

    // FSM and position registers load only on the frame tick.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            tl_q    <= TL_RST;
        end else if (tick) begin
            state_q <= state_d;
            hold_q  <= hold_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tl_q    <= tl_d;
        end
    end

    assign oX         = x_q;
    assign oY         = y_q;
    assign oTopLeft   = tl_q;
    assign oFrameTick = frame_tick_q;
    assign oFast      = (state_q == ST_FAST);

endmodule
